outer_loop_ctrl: RTL and testbench
==================================

Name: outer_loop_ctrl

Overview:
- Sequencer for the blitter outer-loop counter chain: loads the count, launches one inner-loop pass per outer iteration, and steps the counter after each pass.
- Drives the chain's load strobe and step strobe.
- Keeps a synchronous shadow of the count so downstream logic and the bench see the value without sampling the ripple chain.
- Sits between the blitter command/start logic and the inner-loop engine.

Parameters:
- WIDTH, 8, outer counter width in bits. Load value 0 means 2^WIDTH iterations.

Ports:
- MasterClock  input  1  system clock; all state changes on the rising edge.
- RESETL  input  1  synchronous reset, active low.
- start  input  1  begin outer sequence; honoured only in IDLE.
- load_val  input  WIDTH  iteration count; sampled on an accepted start.
- inner_done  input  1  one-cycle pulse from the inner engine at the end of a pass.
- hold  input  1  bus not granted; freezes the LAUNCH state.
- abort  input  1  cancel the sequence immediately.
- ld  output  1  load strobe to the counter chain, asserted in LOAD.
- step  output  1  count step strobe to the counter chain.
- inner_go  output  1  one-cycle launch pulse to the inner engine.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the sequence completes normally.
- count  output  WIDTH  shadow of the remaining iterations.

Behaviour:
- Reset (RESETL=0 at the edge): state=IDLE, count=0. All strobes, busy and done are 0. Reset overrides everything, including mid-sequence.
- Outputs decode directly from registered state, with no combinational path from inputs except as noted for inner_go.
  - ld = LOAD.
  - inner_go = LAUNCH & ~hold.
  - step = STEP | FINISH.
  - done = FINISH.
  - busy = state != IDLE.
- IDLE:
  - start=1 -> LOAD; count <= load_val on the same edge.
  - Otherwise stay in IDLE.
- LOAD: one cycle, then -> LAUNCH.
- LAUNCH:
  - hold=1 -> stay in LAUNCH; inner_go stays low.
  - hold=0 -> WAIT after one cycle with inner_go high.
- WAIT:
  - inner_done=1 and count==1 -> FINISH.
  - inner_done=1 and count!=1 -> STEP.
  - Otherwise stay in WAIT (no timeout).
- STEP: count <= count-1 (modulo 2^WIDTH), then -> LAUNCH.
- FINISH: count <= count-1 (reaches 0), then -> IDLE.
- Latency:
  - start accepted at edge N: ld high in cycle N+1, first inner_go in cycle N+2 (if hold=0).
  - inner_done sampled at edge K: step/done in cycle K+1.
  - Next inner_go in cycle K+2.
- Iterations: number of inner_go pulses = load_val, or 2^WIDTH when load_val=0. A load of 0 decrements to all-ones at the first STEP, which gives this wrap with no special case.
- abort=1 in any non-IDLE state:
  - -> IDLE next edge, with no done pulse and no step.
  - count holds its current value.
  - abort in IDLE has no effect.
- Simultaneous events:
  - abort beats inner_done.
  - abort beats start, which is ignored because start is only honoured in IDLE.
  - start while busy is ignored and not queued.
  - inner_done outside WAIT is ignored.
- A start asserted in the cycle that done is high is still in FINISH, so it is ignored. A new start is accepted from the first IDLE cycle.

Decomposition:
- Shared package outer_loop_pkg:
  - state enum outer_state_t: IDLE, LOAD, LAUNCH, WAIT, STEP, FINISH.
  - OUTER_WIDTH default constant (8).
- One sub-module is natural: outer_down_counter, a WIDTH-bit register with synchronous active-low reset, a load port (load/d) and a decrement enable, exposing count and an is_one flag.
- The FSM stays in outer_loop_ctrl.

Test Plan:
- Basic run: reset, load_val=3, start one cycle, inner engine model returns inner_done 2 cycles after each inner_go -> exactly 3 inner_go, 1 ld, 3 step pulses, done once, count sequence 3,2,1,0, busy drops the cycle after done.
- Wrap case: WIDTH=4 instance, load_val=0 -> 16 inner_go pulses, count after the first STEP = 4'hF, done once, final count 0.
- Hold: hold=1 for 5 cycles while in LAUNCH, load_val=2 -> inner_go is delayed exactly 5 cycles and fires once per iteration; total inner_go = 2.
- Abort: load_val=5, abort during WAIT after the 2nd inner_go -> IDLE next cycle, no done, count=4; abort asserted together with inner_done -> same result, no step.
- Start while busy: second start with load_val=9 mid-sequence -> ignored, original 3-iteration run completes; start in the done cycle is ignored, and start one cycle later is accepted.
- Reset mid-operation: RESETL low for 1 cycle in STEP -> next cycle state IDLE, count=0, all outputs 0; a subsequent start behaves as the basic run.

Source files
------------

// File: rtl/outer_loop_pkg.sv
// outer_loop_pkg: shared state encoding and default width for the outer-loop sequencer
package outer_loop_pkg;
  localparam int OUTER_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT, STEP, FINISH} outer_state_t;
endpackage

// File: rtl/outer_loop_ctrl_if.sv
// outer_loop_ctrl_if: command, inner-engine and counter-chain signals of the outer-loop sequencer
interface outer_loop_ctrl_if
  import outer_loop_pkg::*;
#(
  parameter int WIDTH = OUTER_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             inner_done;
  logic             hold;
  logic             abort;
  logic             ld;
  logic             step;
  logic             inner_go;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;
  modport master (output start, load_val, inner_done, hold, abort,
                  input ld, step, inner_go, busy, done, count);
  modport slave (input start, load_val, inner_done, hold, abort,
                 output ld, step, inner_go, busy, done, count);
endinterface

// File: rtl/outer_down_counter.sv
// outer_down_counter: loadable down counter shadowing the outer ripple chain
module outer_down_counter
  import outer_loop_pkg::*;
#(
  parameter int WIDTH = OUTER_WIDTH
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);
  // load wins over decrement; decrement wraps so a load of 0 yields 2^WIDTH passes
  always_ff @(posedge MasterClock)
    if (!RESETL) count <= '0;
    else if (load) count <= d;
    else if (dec) count <= count - WIDTH'(1);
  assign is_one = count == WIDTH'(1);
endmodule

// File: rtl/outer_loop_ctrl.sv
// outer_loop_ctrl: sequences load, inner-pass launches and steps of the blitter outer counter
module outer_loop_ctrl
  import outer_loop_pkg::*;
#(
  parameter int WIDTH = OUTER_WIDTH
) (
  input logic              MasterClock,
  input logic              RESETL,
  outer_loop_ctrl_if.slave bus
);
  outer_state_t     state, nxt;
  logic             is_one;
  logic [WIDTH-1:0] cnt;
  outer_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .MasterClock(MasterClock),
    .RESETL(RESETL),
    .load(state == IDLE && bus.start),
    .dec((state == STEP || state == FINISH) && !bus.abort),
    .d(bus.load_val),
    .count(cnt),
    .is_one(is_one)
  );
  // state register
  always_ff @(posedge MasterClock)
    if (!RESETL) state <= IDLE;
    else state <= nxt;
  // next state; abort drops any active sequence back to IDLE ahead of all other events
  always_comb begin
    nxt = state;
    if (bus.abort && state != IDLE) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = bus.start ? LOAD : IDLE;
        LOAD:    nxt = LAUNCH;
        LAUNCH:  nxt = bus.hold ? LAUNCH : WAIT;
        WAIT:    nxt = !bus.inner_done ? WAIT : is_one ? FINISH : STEP;
        STEP:    nxt = LAUNCH;
        FINISH:  nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  assign bus.ld       = state == LOAD;
  assign bus.inner_go = state == LAUNCH && !bus.hold;
  assign bus.step     = state == STEP || state == FINISH;
  assign bus.done     = state == FINISH;
  assign bus.busy     = state != IDLE;
  assign bus.count    = cnt;
endmodule

// File: tb/tb_outer_loop_ctrl.sv
// tb_outer_loop_ctrl: scoreboard bench for the outer-loop sequencer (8-bit and 4-bit instances)
module tb_outer_loop_ctrl;
  typedef struct {int k; int c;} ev_t;
  logic clk = 1'b0;
  logic rstl = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  q8[$];
  ev_t  q4[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  outer_loop_ctrl_if #(.WIDTH(8)) b8 ();
  outer_loop_ctrl_if #(.WIDTH(4)) b4 ();
  outer_loop_ctrl #(.WIDTH(8)) d8 (.MasterClock(clk), .RESETL(rstl), .bus(b8));
  outer_loop_ctrl #(.WIDTH(4)) d4 (.MasterClock(clk), .RESETL(rstl), .bus(b4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int w, input int k, input int c);
    ev_t e;
    e.k = k;
    e.c = c;
    if (w == 8) q8.push_back(e);
    else q4.push_back(e);
  endtask

  // kinds: 0=ld 1=inner_go 2=step 3=done; count is the shadow value during that strobe
  task automatic exp_run(input int w, input int n);
    int c;
    int m;
    c = n;
    m = (w == 8) ? 255 : 15;
    push(w, 0, c);
    do begin
      push(w, 1, c);
      push(w, 2, c);
      if (c == 1) push(w, 3, 1);
      c = (c - 1) & m;
    end while (c != 0);
  endtask

  task automatic pop(input int w, input int k, input int c);
    ev_t e;
    checks++;
    if ((w == 8 && q8.size() == 0) || (w == 4 && q4.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_event dut%0d got kind=%0d count=%0d required=none at cycle %0d", w, k, c, cyc);
    end else begin
      if (w == 8) e = q8.pop_front();
      else e = q4.pop_front();
      if (e.k != k || e.c != c) begin
        failures++;
        $display("FAIL event dut%0d got kind=%0d count=%0d required kind=%0d count=%0d at cycle %0d",
                 w, k, c, e.k, e.c, cyc);
      end
    end
  endtask

  // monitor: every strobe the DUTs present is matched against the scoreboard queues
  always @(negedge clk) begin
    if (b8.ld === 1'b1) pop(8, 0, int'(b8.count));
    if (b8.inner_go === 1'b1) pop(8, 1, int'(b8.count));
    if (b8.step === 1'b1) pop(8, 2, int'(b8.count));
    if (b8.done === 1'b1) pop(8, 3, int'(b8.count));
    if (b4.ld === 1'b1) pop(4, 0, int'(b4.count));
    if (b4.inner_go === 1'b1) pop(4, 1, int'(b4.count));
    if (b4.step === 1'b1) pop(4, 2, int'(b4.count));
    if (b4.done === 1'b1) pop(4, 3, int'(b4.count));
  end

  // inner engine model: inner_done two cycles after each inner_go
  initial begin
    b8.inner_done = 1'b0;
    forever begin
      @(negedge clk);
      if (b8.inner_go === 1'b1) begin
        tick;
        tick;
        b8.inner_done = 1'b1;
        tick;
        b8.inner_done = 1'b0;
      end
    end
  end

  initial begin
    b4.inner_done = 1'b0;
    forever begin
      @(negedge clk);
      if (b4.inner_go === 1'b1) begin
        tick;
        tick;
        b4.inner_done = 1'b1;
        tick;
        b4.inner_done = 1'b0;
      end
    end
  end

  function automatic logic sig(input int w, input int s);
    logic [3:0] v;
    if (w == 8) v = {b8.inner_go, b8.step, b8.done, ~b8.busy};
    else v = {b4.inner_go, b4.step, b4.done, ~b4.busy};
    return v[s];
  endfunction

  // s: 0=idle 1=done 2=step 3=inner_go
  task automatic wait_for(input string nm, input int w, input int s, input int lim);
    int n;
    n = 0;
    while (sig(w, s) !== 1'b1 && n < lim) begin
      tick;
      n++;
    end
    checks++;
    if (sig(w, s) !== 1'b1) begin
      failures++;
      $display("FAIL %s timeout dut%0d got no event after %0d cycles required event", nm, w, n);
    end
  endtask

  task automatic start8(input int n);
    b8.load_val = 8'(n);
    b8.start = 1'b1;
    tick;
    b8.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish required finish");
    $fatal(1);
  end

  initial begin
    b8.start = 1'b0; b8.load_val = '0; b8.hold = 1'b0; b8.abort = 1'b0;
    b4.start = 1'b0; b4.load_val = '0; b4.hold = 1'b0; b4.abort = 1'b0;
    repeat (3) tick;
    chk1("rst_ld", b8.ld, 1'b0);
    chk1("rst_step", b8.step, 1'b0);
    chk1("rst_go", b8.inner_go, 1'b0);
    chk1("rst_busy", b8.busy, 1'b0);
    chk1("rst_done", b8.done, 1'b0);
    chkn("rst_count", int'(b8.count), 0);
    chk1("rst_busy4", b4.busy, 1'b0);
    chkn("rst_count4", int'(b4.count), 0);
    rstl = 1'b1;
    tick;
    // basic three-iteration run with latency checks
    exp_run(8, 3);
    start8(3);
    chk1("basic_ld", b8.ld, 1'b1);
    chkn("basic_count_ld", int'(b8.count), 3);
    tick;
    chk1("basic_go_latency", b8.inner_go, 1'b1);
    wait_for("basic_done", 8, 1, 60);
    tick;
    chk1("basic_busy_after", b8.busy, 1'b0);
    chkn("basic_count_end", int'(b8.count), 0);
    // load of 0 on the 4-bit instance runs 16 passes
    exp_run(4, 0);
    b4.load_val = 4'd0;
    b4.start = 1'b1;
    tick;
    b4.start = 1'b0;
    wait_for("wrap_done", 4, 1, 200);
    tick;
    chk1("wrap_busy_after", b4.busy, 1'b0);
    chkn("wrap_count_end", int'(b4.count), 0);
    // hold freezes LAUNCH for five cycles
    exp_run(8, 2);
    b8.hold = 1'b1;
    start8(2);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk1("hold_go_low", b8.inner_go, 1'b0);
    end
    tick;
    b8.hold = 1'b0;
    #1;
    chk1("hold_go_release", b8.inner_go, 1'b1);
    wait_for("hold_done", 8, 1, 60);
    tick;
    chk1("hold_busy_after", b8.busy, 1'b0);
    // abort in WAIT after the second launch
    push(8, 0, 5); push(8, 1, 5); push(8, 2, 5); push(8, 1, 4);
    start8(5);
    wait_for("abort_go1", 8, 3, 20);
    tick;
    wait_for("abort_go2", 8, 3, 20);
    tick;
    b8.abort = 1'b1;
    tick;
    b8.abort = 1'b0;
    chk1("abort_busy", b8.busy, 1'b0);
    chk1("abort_done", b8.done, 1'b0);
    chkn("abort_count", int'(b8.count), 4);
    repeat (3) tick;
    chk1("abort_stays_idle", b8.busy, 1'b0);
    // abort coinciding with inner_done
    push(8, 0, 5); push(8, 1, 5); push(8, 2, 5); push(8, 1, 4);
    start8(5);
    wait_for("abid_go1", 8, 3, 20);
    tick;
    wait_for("abid_go2", 8, 3, 20);
    tick;
    tick;
    b8.abort = 1'b1;
    #1;
    chk1("abid_inner_done", b8.inner_done, 1'b1);
    tick;
    b8.abort = 1'b0;
    chk1("abid_busy", b8.busy, 1'b0);
    chk1("abid_step", b8.step, 1'b0);
    chkn("abid_count", int'(b8.count), 4);
    repeat (3) tick;
    // start while busy is ignored; start in done cycle ignored, next cycle accepted
    exp_run(8, 3);
    start8(3);
    tick;
    tick;
    b8.load_val = 8'd9;
    b8.start = 1'b1;
    tick;
    b8.start = 1'b0;
    wait_for("busy_start_done", 8, 1, 60);
    exp_run(8, 7);
    b8.load_val = 8'd7;
    b8.start = 1'b1;
    tick;
    chk1("done_start_ignored", b8.busy, 1'b0);
    tick;
    b8.start = 1'b0;
    chk1("late_start_ld", b8.ld, 1'b1);
    chkn("late_start_count", int'(b8.count), 7);
    wait_for("late_done", 8, 1, 100);
    tick;
    chkn("late_count_end", int'(b8.count), 0);
    // reset during STEP
    push(8, 0, 3); push(8, 1, 3); push(8, 2, 3);
    start8(3);
    wait_for("rstmid_step", 8, 2, 30);
    rstl = 1'b0;
    tick;
    rstl = 1'b1;
    chk1("rstmid_ld", b8.ld, 1'b0);
    chk1("rstmid_step", b8.step, 1'b0);
    chk1("rstmid_go", b8.inner_go, 1'b0);
    chk1("rstmid_busy", b8.busy, 1'b0);
    chk1("rstmid_done", b8.done, 1'b0);
    chkn("rstmid_count", int'(b8.count), 0);
    exp_run(8, 3);
    start8(3);
    chk1("rerun_ld", b8.ld, 1'b1);
    wait_for("rerun_done", 8, 1, 60);
    tick;
    chkn("rerun_count_end", int'(b8.count), 0);
    tick;
    chkn("q8_drained", q8.size(), 0);
    chkn("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
